exec_unit: RTL
==============

Name: exec_unit

Overview:
Execute stage directly downstream of the register bank.
- Consumes the rs1/rs2 operands (data1/data2) and an opcode from decode.
- Computes single-cycle ALU results and iterative 32-bit multiply/divide.
- Returns result, destination address and write enable to the register bank's write port (write_data/rd/reg_write).
- Operands are produced by the register bank on the clk negedge and sampled here on posedge, so they are stable at sampling.

Parameters:
- XLEN, 32, datapath width.
- ITER, 32, iteration cycles for MULU/DIVU/REMU; must equal XLEN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled at posedge only while in IDLE.
- flush  in  1  synchronous abort of any operation in flight.
- op  in  4  operation code.
- a  in  XLEN  operand A (rs1 data).
- b  in  XLEN  operand B (rs2 data).
- rd_in  in  4  destination register address.
- we_in  in  1  instruction writes back.
- busy  out  1  high while an op is in progress (MUL/DIV states, and the cycle a single-cycle op is accepted).
- done  out  1  one-cycle pulse when result is valid.
- result  out  XLEN  computed value, held until the next done.
- rd_out  out  4  latched rd_in, valid with done.
- reg_write  out  1  equals done AND latched we_in.
- zero  out  1  result==0, updated with done.
- illegal  out  1  pulses with done for op 15.

Behaviour:
- Reset (rst_n=1, async): state IDLE; busy, done, reg_write, illegal = 0; result = 0; rd_out = 0; zero = 0; internal counter, accumulators and latches = 0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 1/0), 7 SLTU (unsigned, result 1/0).
  - 8 SLL, 9 SRL, 10 SRA; shift amount b[4:0].
  - 11 MULU (low XLEN bits of the unsigned product).
  - 12 DIVU, 13 REMU.
  - 14 PASSB (result = b).
  - 15 illegal (result 0, illegal=1).
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; no carry or overflow outputs.
- States: IDLE, ITER, DONE.
- IDLE + start + !flush:
  - Latch op, a, b, rd_in, we_in.
  - Single-cycle op (0-10, 14, 15): go to DONE.
  - Ops 11-13: load iteration registers, counter = 0, go to ITER.
- ITER:
  - One shift-add (MULU) or restoring shift-subtract (DIVU/REMU) step per cycle.
  - Counter increments each cycle; after the ITER-th step, go to DONE.
- DONE:
  - done=1 and result/rd_out/zero/illegal/reg_write updated for exactly one cycle.
  - Next state is IDLE.
  - start during DONE is ignored; the next acceptance is the following cycle.
- Latency (start-sampling edge to done high):
  - Single-cycle ops: done high after the next edge (1 clock).
  - MULU/DIVU/REMU: ITER+1 clocks (33 with defaults).
- Throughput: single-cycle ops one per 2 clocks; iterative ops one per ITER+2 clocks.
- busy: 1 in ITER and DONE, 0 in IDLE. Decode holds the instruction while busy.
- start while busy: ignored; latched operands must not change.
- Divide by zero (b==0): DIVU result = all ones, REMU result = a. Still takes full latency.
- flush:
  - Any state: next state IDLE, no done, no reg_write.
  - result/rd_out keep their previous values.
  - flush with start in IDLE: flush wins, start dropped.
- Async reset mid-ITER: immediate return to reset values; the partial result is discarded.
- rd_in==0 is still passed through with reg_write; the register bank discards writes to R0.

Decomposition:
- Shared package exec_pkg:
  - XLEN constant.
  - Opcode localparams (OP_ADD…OP_ILL).
  - State encoding (IDLE/ITER/DONE).
  - Divide-by-zero result constant.
- Sub-module iter_muldiv:
  - Ports: start, mode (mul/div/rem), a, b, flush → busy, valid, value.
  - Holds the counter, accumulator and quotient/remainder registers.
  - exec_unit keeps the FSM, the single-cycle ALU and the output registers.

Test Plan:
- ADD a=32'hFFFFFFFF, b=1, rd_in=5, we_in=1 → one clock later done=1, result=0, zero=1, rd_out=5, reg_write=1.
- SRA a=32'h80000000, b=4 → result=32'hF8000000. SLT a=-1, b=1 → 1. SLTU a=-1, b=1 → 0.
- MULU a=349, b=2 → busy for 33 clocks, done at clock 33, result=698. Pulse start again at clock 10 → ignored, result unchanged.
- DIVU a=349, b=2 → 174. REMU → 1. DIVU b=0 → 32'hFFFFFFFF. REMU b=0 → 349. All at 33-clock latency.
- DIVU started, flush at iteration 12 → no done, busy=0 next clock, result holds the prior value. New ADD accepted next clock completes normally.
- Assert rst_n mid-MULU at iteration 20 → all outputs 0 immediately. op=15 with we_in=1 → result=0, illegal=1, reg_write=1, each for one clock.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants, opcodes and state encodings for the execute stage.
package exec_pkg;

    localparam int XLEN        = 32;
    localparam int ITER_CYCLES = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;
    localparam logic [3:0] OP_PASSB = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIV,
        MD_REM
    } md_mode_t;

    // Quotient returned for an unsigned divide by zero.
    localparam logic [XLEN-1:0] DIV0_QUOT = '1;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic md_mode_t op_to_mode(input logic [3:0] op);
        case (op)
            OP_DIVU: return MD_DIV;
            OP_REMU: return MD_REM;
            default: return MD_MUL;
        endcase
    endfunction

endpackage

// File: rtl/exec_unit_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide/remainder (restoring),
// one step per clock for ITER clocks.
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = exec_pkg::XLEN,
    parameter int ITER = exec_pkg::ITER_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  md_mode_t        mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] value
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_mode_t          mode_q;
    logic [CNT_W-1:0]  cnt;
    // acc: product accumulator or partial remainder.
    // shreg: multiplier (shifting right) or dividend/quotient (shifting left).
    // opnd: multiplicand (shifting left) or divisor.
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   shreg;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   a_q;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;

    assign rem_sh   = {acc, shreg[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, opnd};

    // valid marks the cycle the final step is taken; value is final from the next cycle on.
    assign valid = busy && !flush && (cnt == CNT_W'(ITER - 1));

    always_comb begin
        value = acc;
        case (mode_q)
            MD_DIV:  value = (opnd == '0) ? DIV0_QUOT : shreg;
            MD_REM:  value = (opnd == '0) ? a_q : acc;
            default: value = acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            shreg  <= '0;
            opnd   <= '0;
            a_q    <= '0;
            mode_q <= MD_MUL;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            a_q    <= a;
            mode_q <= mode;
            if (mode == MD_MUL) begin
                shreg <= b;
                opnd  <= a;
            end else begin
                shreg <= a;
                opnd  <= b;
            end
        end else if (busy) begin
            if (mode_q == MD_MUL) begin
                if (shreg[0]) begin
                    acc <= acc + opnd;
                end
                opnd  <= opnd << 1;
                shreg <= shreg >> 1;
            end else if (!rem_diff[XLEN]) begin
                acc   <= rem_diff[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], 1'b1};
            end else begin
                acc   <= rem_sh[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITER - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus iterative MULU/DIVU/REMU, returning
// result, destination and write enable to the register bank write port.
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN = exec_pkg::XLEN,
    parameter int ITER = exec_pkg::ITER_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      rd_in,
    input  logic            we_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      rd_out,
    output logic            reg_write,
    output logic            zero,
    output logic            illegal
);

    localparam int SH_W = $clog2(XLEN);

    state_t                 state;
    logic [3:0]             op_lat;
    logic [3:0]             rd_lat;
    logic                   we_lat;
    logic [XLEN-1:0]        a_lat;
    logic [XLEN-1:0]        b_lat;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SH_W-1:0]        shamt;
    logic [XLEN-1:0]        alu_out;
    logic [XLEN-1:0]        fin;
    logic                   accept;
    logic                   md_start;
    logic                   md_busy;
    logic                   md_valid;
    logic [XLEN-1:0]        md_value;

    assign accept   = (state == ST_IDLE) && start && !flush;
    assign md_start = accept && is_iter_op(op);

    iter_muldiv #(
        .XLEN (XLEN),
        .ITER (ITER)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .flush (flush),
        .mode  (op_to_mode(op)),
        .a     (a),
        .b     (b),
        .busy  (md_busy),
        .valid (md_valid),
        .value (md_value)
    );

    assign sa    = $signed(a_lat);
    assign sb    = $signed(b_lat);
    assign shamt = b_lat[SH_W-1:0];

    // Single-cycle ALU evaluated from the latched instruction during DONE.
    always_comb begin
        alu_out = '0;
        case (op_lat)
            OP_ADD:   alu_out = a_lat + b_lat;
            OP_SUB:   alu_out = a_lat - b_lat;
            OP_AND:   alu_out = a_lat & b_lat;
            OP_OR:    alu_out = a_lat | b_lat;
            OP_XOR:   alu_out = a_lat ^ b_lat;
            OP_NOR:   alu_out = ~(a_lat | b_lat);
            OP_SLT:   alu_out = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (a_lat < b_lat)};
            OP_SLL:   alu_out = a_lat << shamt;
            OP_SRL:   alu_out = a_lat >> shamt;
            OP_SRA:   alu_out = sa >>> shamt;
            OP_PASSB: alu_out = b_lat;
            default:  alu_out = '0;
        endcase
    end

    assign fin = is_iter_op(op_lat) ? md_value : alu_out;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            reg_write <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            op_lat    <= '0;
            rd_lat    <= '0;
            we_lat    <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
        end else begin
            done      <= 1'b0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_lat <= op;
                        a_lat  <= a;
                        b_lat  <= b;
                        rd_lat <= rd_in;
                        we_lat <= we_in;
                        busy   <= 1'b1;
                        state  <= is_iter_op(op) ? ST_ITER : ST_DONE;
                    end
                end
                ST_ITER: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (md_valid) begin
                        state <= ST_DONE;
                    end else if (!md_busy) begin
                        // Engine stopped without finishing: do not wait forever.
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done      <= 1'b1;
                        result    <= fin;
                        rd_out    <= rd_lat;
                        reg_write <= we_lat;
                        zero      <= (fin == '0);
                        illegal   <= (op_lat == OP_ILL);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
